tagged_flux_fifo: RTL

- Storage end of the multi-flux FIFO protocol: the block that actors write into and read from.
- Accepts tagged words {tag, data} on a write_interface (fifo side).
- Holds one independent circular queue per flux.
- Presents first-word-fall-through heads on a read_interface (fifo side), with per-flux empty/full flags.
- Instantiated between every producer/consumer actor pair in the HEVC dataflow, e.g. upstream of derive_real_size_8tap.

---
 rtl/flux_fifo_pkg.sv | 14 +
 rtl/flux_queue.sv | 66 ++++++
 rtl/tagged_flux_fifo.sv | 73 +++++++
 3 files changed

// File: rtl/flux_fifo_pkg.sv
// Shared sizing helpers and elaboration limits for the tagged multi-flux FIFO.
// Pure constants/functions; no logic.
package flux_fifo_pkg;
   localparam int FLUX_MIN = 2;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Count must hold the value DEPTH itself, hence depth+1 states.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/flux_queue.sv
// One circular queue, head visible combinationally; push/pop take effect on the next edge.
// Push while full and pop while empty are dropped; storage itself is not reset.
module flux_queue
   import flux_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 7,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  full
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  push_ok, pop_ok;

   // DEPTH need not be a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = adv(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = adv(rd_ptr_q);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/tagged_flux_fifo.sv
// Tag-routed multi-flux FIFO with FWFT heads; words visible one edge after push, read->dout is combinational.
// Per-flux full/empty flags; pushes to a full flux, pops of an empty flux and out-of-range tags are dropped.
module tagged_flux_fifo
   import flux_fifo_pkg::*;
#(
   parameter int  FLUX       = 2,
   parameter int  DATA_WIDTH = 7,
   parameter int  DEPTH      = 4,
   localparam int TAG_WIDTH  = $clog2(FLUX),
   localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             write,
   output logic [FLUX-1:0]  full,
   input  logic [FLUX-1:0]  read,
   output logic [WIDTH-1:0] dout,
   output logic [FLUX-1:0]  empty
);
   if (FLUX < FLUX_MIN) begin : g_bad_flux
      $error("tagged_flux_fifo: FLUX must be >= %0d", FLUX_MIN);
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("tagged_flux_fifo: DEPTH must be >= 2");
   end

   logic [TAG_WIDTH-1:0]  wr_tag;
   logic [TAG_WIDTH-1:0]  sel;
   logic [FLUX-1:0]       push;
   logic [FLUX-1:0]       pop;
   logic [DATA_WIDTH-1:0] head [FLUX];

   assign wr_tag = din[WIDTH-1 -: TAG_WIDTH];

   // Lowest read bit wins; otherwise show the lowest non-empty flux, else flux 0.
   always_comb begin
      sel = '0;
      for (int i = FLUX - 1; i >= 0; i--) begin
         if (!empty[i]) sel = TAG_WIDTH'(i);
      end
      if (|read) begin
         for (int i = FLUX - 1; i >= 0; i--) begin
            if (read[i]) sel = TAG_WIDTH'(i);
         end
      end
   end

   always_comb begin
      pop = '0;
      if (|read) pop[sel] = 1'b1;
   end

   for (genvar f = 0; f < FLUX; f++) begin : g_q
      assign push[f] = write && (wr_tag == TAG_WIDTH'(f));

      flux_queue #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_queue (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[f]),
         .pop   (pop[f]),
         .din   (din[DATA_WIDTH-1:0]),
         .head  (head[f]),
         .empty (empty[f]),
         .full  (full[f])
      );
   end

   assign dout = {sel, head[sel]};
endmodule
